// File: rtl/inv_key_sched.sv
// -----------------------------------------------------------------------------
// inv_key_sched
//   Iterative AES-128 key expander for the decryption datapath. A cipher key is
//   accepted in IDLE and stored as round key 0. Round keys 1..10 are then
//   computed one per clock into an 11-entry register file (EXPAND). Finally the
//   keys are presented in reverse order, 10 down to 0, one per rk_req (SERVE).
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   key_valid    in   cipher key on key_in is valid (sampled in IDLE only)
//   key_in       in   128-bit cipher key, w0 in [127:96], first byte in [127:120]
//   key_ready    out  block accepts a new key (IDLE)
//   rk_valid     out  rk_out holds a valid round key (SERVE)
//   rk_out       out  current round key, same byte order as key_in
//   rk_idx       out  round index of rk_out (10..0)
//   rk_req       in   consumer takes the current key
//   busy         out  expansion in progress (EXPAND)
//   dbg_state_o  out  current FSM state encoding for debug/observation
//
// Handshake
//   A key transfers on a rising edge where key_valid & key_ready are both high.
//   A round key transfers on a rising edge where rk_valid & rk_req are both high.
//   rk_out/rk_idx are driven from registered state only, so a consumer may hold
//   rk_req high and receive one key per clock.
// -----------------------------------------------------------------------------

// Forward AES S-box, table lookup. Byte 0x00 sits in the top byte of the table.
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry a lives at bit offset (255-a)*8, which is {~a, 3'b000}.
  assign y_o = SBOX[{~a_i, 3'b000} +: 8];
endmodule

module inv_key_sched #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [127:0] key_in,
  output logic         key_ready,
  output logic         rk_valid,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_idx,
  input  logic         rk_req,
  output logic         busy,
  output logic [1:0]   dbg_state_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXPAND = 2'd1;
  localparam logic [1:0] S_SERVE  = 2'd2;

  localparam logic [3:0] LAST_RND = 4'(NR);

  logic [1:0]   state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [3:0]   idx_q, idx_d;
  logic [127:0] mem_q [0:NR];

  logic         wr_en;
  logic [3:0]   wr_addr;
  logic [127:0] wr_data;

  // ---------------------------------------------------------------------------
  // One round of the forward key schedule: round key rnd from round key rnd-1.
  // ---------------------------------------------------------------------------
  logic [3:0]   prev_sel;
  logic [127:0] prev_rk;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot_w, sub_w, t_w;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] next_rk;
  logic [7:0]   rcon;

  // rnd is 0 only straight out of reset; keep the read address in range then.
  assign prev_sel = (rnd_q == 4'd0) ? 4'd0 : (rnd_q - 4'd1);
  assign prev_rk  = mem_q[prev_sel];

  assign w0 = prev_rk[127:96];
  assign w1 = prev_rk[95:64];
  assign w2 = prev_rk[63:32];
  assign w3 = prev_rk[31:0];

  assign rot_w = {w3[23:0], w3[31:24]};

  aes_sbox u_sbox0 (.a_i(rot_w[31:24]), .y_o(sub_w[31:24]));
  aes_sbox u_sbox1 (.a_i(rot_w[23:16]), .y_o(sub_w[23:16]));
  aes_sbox u_sbox2 (.a_i(rot_w[15:8]),  .y_o(sub_w[15:8]));
  aes_sbox u_sbox3 (.a_i(rot_w[7:0]),   .y_o(sub_w[7:0]));

  always_comb begin
    rcon = 8'h00;
    case (rnd_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign t_w = sub_w ^ {rcon, 24'h000000};
  assign n0  = w0 ^ t_w;
  assign n1  = w1 ^ n0;
  assign n2  = w2 ^ n1;
  assign n3  = w3 ^ n2;
  assign next_rk = {n0, n1, n2, n3};

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    idx_d   = idx_q;
    wr_en   = 1'b0;
    wr_addr = 4'd0;
    wr_data = key_in;
    case (state_q)
      S_IDLE: begin
        if (key_valid) begin
          wr_en   = 1'b1;
          wr_addr = 4'd0;
          wr_data = key_in;
          rnd_d   = 4'd1;
          state_d = S_EXPAND;
        end
      end
      S_EXPAND: begin
        wr_en   = 1'b1;
        wr_addr = rnd_q;
        wr_data = next_rk;
        if (rnd_q == LAST_RND) begin
          idx_d   = LAST_RND;
          state_d = S_SERVE;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      S_SERVE: begin
        if (rk_req) begin
          if (idx_q != 4'd0) begin
            idx_d = idx_q - 4'd1;
          end else begin
            // Key 0 consumed; the next accept needs a separate IDLE cycle.
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rnd_q   <= 4'd0;
      idx_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      idx_q   <= idx_d;
    end
  end

  // Register file: cleared by reset, otherwise written only during a new
  // accept/expansion, so a finished schedule survives the return to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= NR; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all from registered state)
  // ---------------------------------------------------------------------------
  assign key_ready   = (state_q == S_IDLE);
  assign busy        = (state_q == S_EXPAND);
  assign rk_valid    = (state_q == S_SERVE);
  assign rk_out      = mem_q[idx_q];
  assign rk_idx      = idx_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_inv_key_sched.sv
// -----------------------------------------------------------------------------
// tb_inv_key_sched
//   Directed bench for inv_key_sched using the FIPS-197 example key and the
//   all-zero key, with round-key tables written out by hand.
// -----------------------------------------------------------------------------
module tb_inv_key_sched;

  logic         clk;
  logic         rst;
  logic         key_valid;
  logic [127:0] key_in;
  logic         key_ready;
  logic         rk_valid;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         rk_req;
  logic         busy;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  logic [127:0] fips_rk [0:10];
  logic [127:0] zero_rk [0:10];
  logic [127:0] exp_q [$];

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] OTHER_KEY = 128'hffeeddccbbaa99887766554433221100;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  inv_key_sched #(.NR(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_valid   (key_valid),
    .key_in      (key_in),
    .key_ready   (key_ready),
    .rk_valid    (rk_valid),
    .rk_out      (rk_out),
    .rk_idx      (rk_idx),
    .rk_req      (rk_req),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  task automatic init_vectors();
    fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    zero_rk[0]  = 128'h00000000000000000000000000000000;
    zero_rk[1]  = 128'h62636363626363636263636362636363;
    zero_rk[2]  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
    zero_rk[3]  = 128'h90973450696ccffaf2f457330b0fac99;
    zero_rk[4]  = 128'hee06da7b876a1581759e42b27e91ee2b;
    zero_rk[5]  = 128'h7f2e2b88f8443e098dda7cbbf34b9290;
    zero_rk[6]  = 128'hec614b851425758c99ff09376ab49ba7;
    zero_rk[7]  = 128'h217517873550620bacaf6b3cc61bf09b;
    zero_rk[8]  = 128'h0ef903333ba9613897060a04511dfa9f;
    zero_rk[9]  = 128'hb1d4d8e28a7db9da1d7bb3de4c664941;
    zero_rk[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (no comparisons inside)
  // ---------------------------------------------------------------------------
  // Presents a key for one edge; returns on the negedge after the accept edge.
  task automatic start_key(input logic [127:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key_in    = k;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  // Called on the negedge after the accept edge (count 1). Returns the
  // negedge count at which rk_valid was first seen, or -1 on timeout.
  task automatic wait_valid(output int n);
    n = 1;
    while (!rk_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!rk_valid) n = -1;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; key_valid = 1'b0; key_in = '0; rk_req = 1'b0;
    #3;
    checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL reset_key_ready: got %b expected 1", key_ready); end
    checks++; if (rk_valid !== 1'b0) begin errors++; $display("FAIL reset_rk_valid: got %b expected 0", rk_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (rk_idx !== 4'd0) begin errors++; $display("FAIL reset_rk_idx: got %0d expected 0", rk_idx); end
    checks++; if (rk_out !== 128'h0) begin errors++; $display("FAIL reset_rk_out: got %h expected 0", rk_out); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fips_held();
    int n;
    start_key(FIPS_KEY);
    checks++; if (busy !== 1'b1 || key_ready !== 1'b0) begin errors++; $display("FAIL fips_busy_after_accept: got busy=%b key_ready=%b expected 1/0", busy, key_ready); end
    wait_valid(n);
    checks++; if (n != 11) begin errors++; $display("FAIL fips_latency: got %0d expected 11", n); end
    rk_req = 1'b1;
    for (int i = 10; i >= 0; i--) exp_q.push_back(fips_rk[i]);
    for (int i = 10; i >= 0; i--) begin
      logic [127:0] e;
      e = exp_q.pop_front();
      checks++; if (rk_valid !== 1'b1) begin errors++; $display("FAIL fips_valid[%0d]: got %b expected 1", i, rk_valid); end
      checks++; if (rk_idx !== 4'(i)) begin errors++; $display("FAIL fips_idx: got %0d expected %0d", rk_idx, i); end
      checks++; if (rk_out !== e) begin errors++; $display("FAIL fips_rk[%0d]: got %h expected %h", i, rk_out, e); end
      @(negedge clk);
    end
    rk_req = 1'b0;
    checks++; if (rk_valid !== 1'b0 || key_ready !== 1'b1) begin errors++; $display("FAIL fips_end: got rk_valid=%b key_ready=%b expected 0/1", rk_valid, key_ready); end
  endtask

  task automatic test_zero_key();
    int n;
    start_key(128'h0);
    wait_valid(n);
    checks++; if (n != 11) begin errors++; $display("FAIL zero_latency: got %0d expected 11", n); end
    rk_req = 1'b1;
    for (int i = 10; i >= 0; i--) exp_q.push_back(zero_rk[i]);
    for (int i = 10; i >= 0; i--) begin
      logic [127:0] e;
      e = exp_q.pop_front();
      checks++; if (rk_idx !== 4'(i)) begin errors++; $display("FAIL zero_idx: got %0d expected %0d", rk_idx, i); end
      checks++; if (rk_out !== e) begin errors++; $display("FAIL zero_rk[%0d]: got %h expected %h", i, rk_out, e); end
      @(negedge clk);
    end
    rk_req = 1'b0;
    checks++; if (rk_valid !== 1'b0 || key_ready !== 1'b1) begin errors++; $display("FAIL zero_end: got rk_valid=%b key_ready=%b expected 0/1", rk_valid, key_ready); end
  endtask

  task automatic test_sparse_req();
    int n;
    int delivered;
    start_key(FIPS_KEY);
    // rk_req pulses during EXPAND must not disturb anything.
    rk_req = 1'b1;
    n = 1;
    while (!rk_valid && n < 40) begin
      if (n == 5) rk_req = 1'b0;
      @(negedge clk);
      n++;
    end
    rk_req = 1'b0;
    checks++; if (n != 11) begin errors++; $display("FAIL sparse_latency: got %0d expected 11", n); end
    delivered = 0;
    for (int i = 10; i >= 0; i--) begin
      checks++; if (rk_idx !== 4'(i) || rk_out !== fips_rk[i]) begin errors++; $display("FAIL sparse_key: got idx %0d %h expected idx %0d %h", rk_idx, rk_out, i, fips_rk[i]); end
      else delivered++;
      for (int h = 0; h < 2; h++) begin
        @(negedge clk);
        checks++; if (rk_idx !== 4'(i) || rk_out !== fips_rk[i] || rk_valid !== 1'b1) begin errors++; $display("FAIL sparse_stable: got idx %0d valid %b expected idx %0d valid 1", rk_idx, rk_valid, i); end
      end
      rk_req = 1'b1;
      @(negedge clk);
      rk_req = 1'b0;
    end
    checks++; if (delivered != 11) begin errors++; $display("FAIL sparse_count: got %0d expected 11", delivered); end
    checks++; if (rk_valid !== 1'b0 || key_ready !== 1'b1) begin errors++; $display("FAIL sparse_end: got rk_valid=%b key_ready=%b expected 0/1", rk_valid, key_ready); end
    // rk_req with nothing to serve: no effect.
    rk_req = 1'b1;
    repeat (3) @(negedge clk);
    rk_req = 1'b0;
    checks++; if (rk_valid !== 1'b0 || key_ready !== 1'b1 || busy !== 1'b0 || rk_idx !== 4'd0) begin errors++; $display("FAIL sparse_idle_req: got valid %b ready %b busy %b idx %0d expected 0 1 0 0", rk_valid, key_ready, busy, rk_idx); end
  endtask

  task automatic test_ignore_key_valid();
    int n;
    start_key(FIPS_KEY);
    key_valid = 1'b1;
    key_in    = OTHER_KEY;
    wait_valid(n);
    checks++; if (n != 11) begin errors++; $display("FAIL ignore_latency: got %0d expected 11", n); end
    rk_req = 1'b1;
    for (int i = 10; i >= 0; i--) begin
      checks++; if (rk_idx !== 4'(i) || rk_out !== fips_rk[i]) begin errors++; $display("FAIL ignore_key: got idx %0d %h expected idx %0d %h", rk_idx, rk_out, i, fips_rk[i]); end
      key_valid = (i >= 3);
      @(negedge clk);
    end
    rk_req = 1'b0;
    key_valid = 1'b0;
    checks++; if (rk_valid !== 1'b0 || key_ready !== 1'b1) begin errors++; $display("FAIL ignore_end: got rk_valid=%b key_ready=%b expected 0/1", rk_valid, key_ready); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || key_ready !== 1'b1) begin errors++; $display("FAIL ignore_no_accept: got busy=%b key_ready=%b expected 0/1", busy, key_ready); end
  endtask

  task automatic test_reset_mid_expand();
    int n;
    start_key(OTHER_KEY);
    repeat (4) @(negedge clk);
    // Between the edges E4 and E5; reset must act without a clock edge.
    #2;
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || key_ready !== 1'b1 || rk_valid !== 1'b0) begin errors++; $display("FAIL rst_async_flags: got busy %b ready %b valid %b expected 0 1 0", busy, key_ready, rk_valid); end
    checks++; if (rk_idx !== 4'd0 || rk_out !== 128'h0) begin errors++; $display("FAIL rst_async_out: got idx %0d %h expected 0 0", rk_idx, rk_out); end
    @(negedge clk);
    rst = 1'b0;
    start_key(FIPS_KEY);
    wait_valid(n);
    checks++; if (n != 11) begin errors++; $display("FAIL rst_latency: got %0d expected 11", n); end
    rk_req = 1'b1;
    for (int i = 10; i >= 0; i--) begin
      checks++; if (rk_idx !== 4'(i) || rk_out !== fips_rk[i]) begin errors++; $display("FAIL rst_rekey: got idx %0d %h expected idx %0d %h", rk_idx, rk_out, i, fips_rk[i]); end
      @(negedge clk);
    end
    rk_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n;
    rk_req = 1'b1;
    @(negedge clk);
    key_valid = 1'b1;
    key_in    = FIPS_KEY;
    @(negedge clk);
    key_in    = 128'h0;
    wait_valid(n);
    checks++; if (n != 11) begin errors++; $display("FAIL b2b_latency1: got %0d expected 11", n); end
    for (int i = 10; i >= 0; i--) begin
      checks++; if (rk_idx !== 4'(i) || rk_out !== fips_rk[i]) begin errors++; $display("FAIL b2b_key1: got idx %0d %h expected idx %0d %h", rk_idx, rk_out, i, fips_rk[i]); end
      @(negedge clk);
    end
    checks++; if (rk_valid !== 1'b0 || key_ready !== 1'b1) begin errors++; $display("FAIL b2b_gap: got rk_valid=%b key_ready=%b expected 0/1", rk_valid, key_ready); end
    @(negedge clk);
    key_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept2: got busy=%b expected 1", busy); end
    wait_valid(n);
    checks++; if (n != 11) begin errors++; $display("FAIL b2b_latency2: got %0d expected 11", n); end
    for (int i = 10; i >= 0; i--) begin
      checks++; if (rk_idx !== 4'(i) || rk_out !== zero_rk[i]) begin errors++; $display("FAIL b2b_key2: got idx %0d %h expected idx %0d %h", rk_idx, rk_out, i, zero_rk[i]); end
      @(negedge clk);
    end
    rk_req = 1'b0;
    checks++; if (rk_valid !== 1'b0 || key_ready !== 1'b1) begin errors++; $display("FAIL b2b_end: got rk_valid=%b key_ready=%b expected 0/1", rk_valid, key_ready); end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    init_vectors();
    test_reset();
    test_fips_held();
    test_zero_key();
    test_sparse_req();
    test_ignore_key_valid();
    test_reset_mid_expand();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
